tri_drive_arbiter: RTL and testbench
====================================

# tri_drive_arbiter

Upstream control stage for the shared tristate 2-to-1 flip-flop stage. Two requesters compete for the single tristate output. This block arbitrates them round-robin with a bounded hold time and produces the registered enable `e` and data `i` that the tristate stage consumes. It guarantees that `e` is only high while exactly one owner is granted, and can optionally insert a bus-turnaround cycle on every owner change.

## Interface
- `DW`, default 2: width of each requester's data and of `i`.
- `MAX_HOLD`, default 4: maximum consecutive owned cycles while the other side is waiting; must be ≥1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  request per requester; bit k = requester k.
- `din0`  in  DW  data of requester 0.
- `din1`  in  DW  data of requester 1.
- `e`  out  1  registered enable to the tristate stage; high only while an owner is granted.
- `i`  out  DW  registered data to the tristate stage.
- `gnt`  out  2  registered one-hot-or-zero grant.
- `owner`  out  1  index of the current/last owner; also serves as the round-robin pointer.

## Operation
- States:
  - IDLE
  - OWN0
  - OWN1
  - TURN (exists only with the macro, see Configuration)
- Outputs per state:
  - IDLE: `e`=0, `gnt`=00, `i` holds its last value.
  - OWNk: `e`=1, `gnt[k]`=1, `i`=`dink` sampled every edge.
  - TURN: `e`=0, `gnt`=00.
- IDLE transitions:
  - Only `req[k]` set: go to OWNk.
  - Both set: go to the requester that is NOT `owner`. After reset `owner`=1, so requester 0 wins the first tie.
  - `req`=00: stay in IDLE.
- Hold counter `hc`:
  - Reset to 1 on entry to OWNk.
  - Increments each cycle in OWNk and saturates at `MAX_HOLD`.
- OWNk exit conditions, evaluated on each edge:
  - Release: `req[k]`=0.
  - Preempt: `hc`==`MAX_HOLD` and `req[other]`=1.
  - Release or preempt with `req[other]`=1: go to OWN(other), or via TURN when the macro is on.
  - Release with `req[other]`=0: go to IDLE.
  - Otherwise: stay in OWNk. Saturated `hc` with no competitor keeps ownership indefinitely.
- A preempted requester that still holds `req` re-competes normally and is granted again after the other side releases or is preempted.
- `owner` updates on every entry to OWNk.
- Invariants, checked every cycle:
  - `gnt` is never 11.
  - `e` == `gnt[0] | gnt[1]`.
  - `i` changes only while `e`=1.
- Reset: `e`=0, `gnt`=00, `i`=0, `owner`=1, `hc`=0, state IDLE. Reset takes effect on the next edge, including mid-ownership and in TURN.
- Changes on `req` between edges have no effect; only sampled values matter.

## Timing
- Grant latency: `req` sampled at edge n → `gnt`, `e`, `i` valid after edge n (one cycle).
- Data latency: `i` follows `dink` by exactly one cycle while OWNk.
- Release latency: `req[k]` low at edge n → `e` low after edge n.
- Back-to-back owner change without the macro: OWN0 at edge n, OWN1 at edge n+1. `e` stays 1 and `gnt` goes 01→10 with no gap.
- Owner change with the macro: OWN0 at edge n, TURN at edge n+1, OWN1 at edge n+2. There is exactly one cycle of `e`=0.
- Maximum wait for a requester that holds `req` continuously: `MAX_HOLD` cycles, plus 1 with the macro, plus 1 grant latency.

## Configuration
- Macro `TRI_DRIVE_TURNAROUND_EN`.
- Defined:
  - Every direct owner change passes through TURN for one cycle with `e`=0 and `gnt`=00.
  - TURN always proceeds to the pending owner, even if that owner dropped `req` during TURN. It then releases normally one cycle later.
  - Reset in TURN → IDLE.
- Undefined: the TURN state and its logic are absent, and owner changes are direct.

## Test plan
- Reset: assert `rst` for 2 cycles with `req`=11 → `e`=0, `gnt`=00, `i`=00, `owner`=1. Release `rst` → one cycle later `gnt`=01, `e`=1, `i`=`din0`.
- Single requester: `req`=10, `din1`=2'b10 for 6 cycles → `gnt`=10 from cycle 1 to cycle 6, `i`=10. Drop `req` → `e`=0 one cycle later.
- Preemption with `MAX_HOLD`=4: `req` held at 11 → `gnt` = 01 ×4, 10 ×4, 01 ×4, … With `TRI_DRIVE_TURNAROUND_EN` → 01 ×4, 00, 10 ×4, 00, …
- No competitor: `req`=01 for 20 cycles → `gnt`=01 throughout. `hc` saturates at 4 with no release.
- Reset mid-op: in OWN1 with `i`=11, pulse `rst` for 1 cycle → next cycle `e`=0, `gnt`=00, `i`=00. With `req`=11 afterwards, requester 0 is granted first.
- Tie after release: owner 0 drops `req` while `req`=10 → OWN1 next cycle, or TURN then OWN1 with the macro. Then `req`=11 from IDLE after both release → requester 0 is granted, since `owner`=1.

Source files
------------

// File: rtl/tri_drive_arbiter.sv
// Round-robin, hold-bounded owner arbitration feeding a shared tristate stage.
// Define TRI_DRIVE_TURNAROUND_EN to insert a one-cycle TURN gap on every owner change.
module tri_drive_arbiter #(
    parameter int DW       = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          e,
    output logic [DW-1:0] i,
    output logic [1:0]    gnt,
    output logic          owner
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
`ifdef TRI_DRIVE_TURNAROUND_EN
        , TURN = 2'd3
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hc;
    logic          cur, hand_off, owns_nxt;

    function automatic state_t own_of(input logic k);
        return k ? OWN1 : OWN0;
    endfunction

    // cur is only meaningful in OWNk; hand_off covers both release and preemption
    assign cur      = (state == OWN1);
    assign hand_off = !req[cur] || (hc == HMAX && req[~cur]);
    assign owns_nxt = (state_nxt == OWN0) || (state_nxt == OWN1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req == 2'b11)  state_nxt = own_of(~owner);
                else if (req[0])   state_nxt = OWN0;
                else if (req[1])   state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (hand_off) begin
                    if (!req[~cur]) state_nxt = IDLE;
`ifdef TRI_DRIVE_TURNAROUND_EN
                    else            state_nxt = TURN;
`else
                    else            state_nxt = own_of(~cur);
`endif
                end
            end
`ifdef TRI_DRIVE_TURNAROUND_EN
            // owner still names the previous holder, so the pending one is its opposite
            TURN: state_nxt = own_of(~owner);
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hc    <= '0;
            e     <= 1'b0;
            gnt   <= 2'b00;
            i     <= '0;
            owner <= 1'b1;
        end else begin
            state <= state_nxt;
            e     <= owns_nxt;
            gnt   <= {state_nxt == OWN1, state_nxt == OWN0};
            if (state_nxt == OWN0) begin
                i     <= din0;
                owner <= 1'b0;
            end else if (state_nxt == OWN1) begin
                i     <= din1;
                owner <= 1'b1;
            end
            if (!owns_nxt)
                hc <= '0;
            else if (state_nxt != state)
                hc <= HW'(1);
            else if (hc != HMAX)
                hc <= hc + 1'b1;
        end
    end
endmodule

// File: tb/tb_tri_drive_arbiter.sv
// Bench for tri_drive_arbiter: vector table, directed corner sequences and random
// traffic against a bus-ownership model; follows TRI_DRIVE_TURNAROUND_EN if defined.
module tb_tri_drive_arbiter;
    localparam int DW = 2;
    localparam int MH = 4;
`ifdef TRI_DRIVE_TURNAROUND_EN
    localparam int TX = 1;
`else
    localparam int TX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] din0 = '0, din1 = '0;
    logic          e;
    logic [DW-1:0] i;
    logic [1:0]    gnt;
    logic          owner;

    int checks = 0;
    int errors = 0;

    // model: who holds the bus (-1 nobody, 0/1 requester, 2 turnaround gap)
    int            m_own  = -1;
    int            m_last = 1;
    int            m_hold = 0;
    logic [DW-1:0] m_i    = '0;
    int            waitc[2];
    logic [DW-1:0] prev_i;

    typedef struct {
        logic          rst;
        logic [1:0]    req;
        logic [DW-1:0] d0, d1;
        logic          e;
        logic [1:0]    gnt;
        logic [DW-1:0] i;
        logic          owner;
    } vec_t;
    vec_t tbl[12];

    tri_drive_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1),
        .e(e), .i(i), .gnt(gnt), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter(input int k);
        m_own  = k;
        m_last = k;
        m_hold = 1;
    endtask

    task automatic model_edge();
        int k;
        if (rst) begin
            m_own = -1; m_last = 1; m_hold = 0; m_i = '0;
            return;
        end
        if (m_own == -1) begin
            if (req == 2'b11)  enter(1 - m_last);
            else if (req[0])   enter(0);
            else if (req[1])   enter(1);
        end else if (m_own == 2) begin
            enter(1 - m_last);
        end else begin
            k = m_own;
            if (!req[k] || (m_hold == MH && req[1-k])) begin
                if (!req[1-k])   m_own = -1;
                else if (TX != 0) m_own = 2;
                else             enter(1 - k);
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
        if (m_own == 0)      m_i = din0;
        else if (m_own == 1) m_i = din1;
    endtask

    task automatic step();
        logic       s_rst;
        logic [1:0] s_req;
        @(posedge clk);
        s_rst = rst;
        s_req = req;
        model_edge();
        #1;
        chk("gnt_onehot", int'(gnt == 2'b11), 0);
        chk("e_vs_gnt", int'(e), int'(gnt[0] | gnt[1]));
        if (!s_rst)
            chk("i_hold_idle", int'(!e && i != prev_i), 0);
        chk("m_gnt", int'(gnt), (m_own == 0) ? 1 : (m_own == 1) ? 2 : 0);
        chk("m_e", int'(e), int'(m_own == 0 || m_own == 1));
        chk("m_i", int'(i), int'(m_i));
        chk("m_owner", int'(owner), m_last);
        for (int k = 0; k < 2; k++) begin
            if (s_rst || !s_req[k] || gnt[k]) waitc[k] = 0;
            else                              waitc[k]++;
            chk("wait_bound", int'(waitc[k] <= MH + TX), 1);
        end
        prev_i = i;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        waitc[0] = 0;
        waitc[1] = 0;
        tbl[0]  = '{1'b1, 2'b11, 2'd1, 2'd2, 1'b0, 2'b00, 2'd0, 1'b1};
        tbl[1]  = '{1'b1, 2'b11, 2'd1, 2'd2, 1'b0, 2'b00, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 2'b11, 2'd1, 2'd2, 1'b1, 2'b01, 2'd1, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 2'd3, 2'd2, 1'b1, 2'b01, 2'd3, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 2'd0, 2'd0, 1'b0, 2'b00, 2'd3, 1'b0};
        tbl[5]  = '{1'b0, 2'b10, 2'd0, 2'd2, 1'b1, 2'b10, 2'd2, 1'b1};
        tbl[6]  = '{1'b0, 2'b10, 2'd0, 2'd3, 1'b1, 2'b10, 2'd3, 1'b1};
        tbl[7]  = '{1'b1, 2'b10, 2'd0, 2'd3, 1'b0, 2'b00, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 2'b11, 2'd2, 2'd1, 1'b1, 2'b01, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, 2'd1, 2'd1, 1'b0, 2'b00, 2'd2, 1'b0};
        tbl[10] = '{1'b0, 2'b11, 2'd0, 2'd1, 1'b1, 2'b10, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 2'b00, 2'd3, 2'd3, 1'b0, 2'b00, 2'd1, 1'b1};

        for (int n = 0; n < 12; n++) begin
            rst = tbl[n].rst; req = tbl[n].req; din0 = tbl[n].d0; din1 = tbl[n].d1;
            step();
            chk($sformatf("tbl%0d_e", n), int'(e), int'(tbl[n].e));
            chk($sformatf("tbl%0d_gnt", n), int'(gnt), int'(tbl[n].gnt));
            chk($sformatf("tbl%0d_i", n), int'(i), int'(tbl[n].i));
            chk($sformatf("tbl%0d_owner", n), int'(owner), int'(tbl[n].owner));
        end

        // continuous contention: fixed rotation with optional gap cycle
        do_reset();
        req = 2'b11; din0 = 2'd1; din1 = 2'd2;
        for (int n = 0; n < 24; n++) begin
            int pos, exp_g;
            step();
            pos   = n % (2 * (MH + TX));
            exp_g = (pos < MH) ? 1 : (pos == MH && TX != 0) ? 0 :
                    (pos < 2 * MH + TX) ? 2 : 0;
            chk("rotate_gnt", int'(gnt), exp_g);
        end

        // lone requester never loses the bus once hold saturates
        do_reset();
        req = 2'b01;
        for (int n = 0; n < 20; n++) begin
            din0 = DW'(n);
            step();
            chk("solo_gnt", int'(gnt), 1);
            chk("solo_i", int'(i), n % (1 << DW));
        end

        // release hand-off, then tie from IDLE goes to requester 0
        do_reset();
        req = 2'b01; din1 = 2'd3;
        step();
        chk("ho_own0", int'(gnt), 1);
        req = 2'b10;
        step();
        chk("ho_first", int'(gnt), (TX != 0) ? 0 : 2);
        step();
        chk("ho_own1", int'(gnt), 2);
        req = 2'b00;
        step();
        chk("ho_idle", int'(e), 0);
        req = 2'b11; din0 = 2'd2;
        step();
        chk("ho_tie_gnt", int'(gnt), 1);
        chk("ho_tie_owner", int'(owner), 0);

        // random traffic with occasional reset
        for (int n = 0; n < 500; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) req = 2'($urandom_range(0, 3));
            din0 = DW'($urandom);
            din1 = DW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
